mode_debounce: RTL

MODE_DEBOUNCE -- requirements
Module: mode_debounce

---
 rtl/mode_debounce.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mode_debounce.sv
// mode_debounce
//   Debounces a 2-bit slide switch into a registered mode value for the
//   LED pattern FSM. The raw switch is first synchronized through two flops.
//   A new value is accepted only after it has been seen unchanged for
//   DEBOUNCE_CYCLES consecutive clocks.
//
// Parameters
//   DEBOUNCE_CYCLES  clocks a new value must hold before it is accepted (>= 2)
//   CNT_W            qualification counter width
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   sw[1:0]       raw, asynchronous, bouncing switch levels
//   mode[1:0]     debounced switch value (registered)
//   mode_changed  one-cycle pulse on every update of mode (registered)
//   busy          high while a candidate value is being qualified
//
// state   | meaning
// --------+--------------------------------------------------------------
// STABLE  | synchronized switch matches mode; counter parked at 0
// QUALIFY | candidate differs from mode; counting clocks it stays steady

module mode_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       busy
);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1;
  logic [1:0]       sync_sw;
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cand;
  logic [1:0]       cand_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       mode_nxt;
  logic             changed_nxt;

  // Two-flop synchronizer; nothing else may look at sw.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 2'b00;
      sync_sw <= 2'b00;
    end else begin
      sync1   <= sw;
      sync_sw <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= STABLE;
      cand         <= 2'b00;
      cnt          <= '0;
      mode         <= 2'b00;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      cnt          <= cnt_nxt;
      mode         <= mode_nxt;
      mode_changed <= changed_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    mode_nxt    = mode;
    changed_nxt = 1'b0;
    case (state)
      STABLE: begin
        cnt_nxt = '0;
        if (sync_sw != mode) begin
          cand_nxt  = sync_sw;
          state_nxt = QUALIFY;
        end
      end
      QUALIFY: begin
        if (sync_sw == cand) begin
          if (cnt == CNT_LAST) begin
            mode_nxt    = cand;
            changed_nxt = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = STABLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else if (sync_sw == mode) begin
          // Bounced back to the accepted value: drop the candidate quietly.
          cnt_nxt   = '0;
          state_nxt = STABLE;
        end else begin
          // A third value appeared: restart qualification on it.
          cand_nxt = sync_sw;
          cnt_nxt  = '0;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = STABLE;
      end
    endcase
  end

  assign busy = (state == QUALIFY);

endmodule
